// File: rtl/slink_generic_tx_router_wrr_pkg.sv
// Shared types and constants for the packet-aware WRR transmit router.
package slink_generic_tx_router_wrr_pkg;

  localparam logic [7:0] SHORT_PKT_MAX_ID = 8'h1F;
  localparam int         BEAT_W           = 17;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Advances per packet; the header advance is the first of them.
  function automatic beat_t pkt_beats(input logic [7:0]  data_id,
                                      input logic [15:0] word_count,
                                      input int unsigned byte_shift);
    beat_t sum;
    sum = (beat_t'(word_count) + beat_t'((1 << byte_shift) - 1)) >> byte_shift;
    if (data_id <= SHORT_PKT_MAX_ID || sum == '0) begin
      return beat_t'(1);
    end
    return sum;
  endfunction

endpackage

// File: rtl/slink_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping; purely combinational.
module slink_rr_pick #(
  parameter  int NUM_CHANNELS = 8,
  localparam int IDX_W        = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]        ptr,
  output logic                    found,
  output logic [IDX_W-1:0]        idx
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      // Explicit wrap so non-power-of-two channel counts are handled.
      j = int'(ptr) + i;
      if (j >= NUM_CHANNELS) begin
        j = j - NUM_CHANNELS;
      end
      jj = IDX_W'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/slink_generic_tx_router_wrr.sv
// Weighted round-robin mux of N app TX channels onto one S-Link TX app port, grant held per packet.
// Zero-latency select/mux; backpressure is the link layer's tx_advance steered to the granted channel only.
module slink_generic_tx_router_wrr
  import slink_generic_tx_router_wrr_pkg::*;
#(
  parameter  int NUM_CHANNELS      = 8,
  parameter  int TX_APP_DATA_WIDTH = 64,
  parameter  int WEIGHT_WIDTH      = 4,
  localparam int IDX_W             = $clog2(NUM_CHANNELS)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [NUM_CHANNELS*WEIGHT_WIDTH-1:0]      weight_ch,
  input  logic [NUM_CHANNELS-1:0]                   tx_sop_ch,
  input  logic [NUM_CHANNELS*8-1:0]                 tx_data_id_ch,
  input  logic [NUM_CHANNELS*16-1:0]                tx_word_count_ch,
  input  logic [NUM_CHANNELS*TX_APP_DATA_WIDTH-1:0] tx_app_data_ch,
  output logic [NUM_CHANNELS-1:0]                   tx_advance_ch,
  output logic                                      tx_sop,
  output logic [7:0]                                tx_data_id,
  output logic [15:0]                               tx_word_count,
  output logic [TX_APP_DATA_WIDTH-1:0]              tx_app_data,
  input  logic                                      tx_advance,
  output logic [IDX_W-1:0]                          active_ch,
  output logic                                      pkt_active
);

  localparam int BYTES      = TX_APP_DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);

  logic                    enable_ff1, enable_ff2;
  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        owner, owner_nxt, rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]        curr_ch, pick_idx;
  beat_t                   beat_cnt, beat_cnt_nxt, hdr_beats;
  logic [WEIGHT_WIDTH-1:0] wgt_cnt, wgt_cnt_nxt, curr_wgt, owner_nxt_wgt;
  logic                    done_pend, done_pend_nxt, pkt_done;
  logic [NUM_CHANNELS-1:0] eligible;
  logic                    pick_found;

  function automatic logic [IDX_W-1:0] rr_inc(input logic [IDX_W-1:0] ch);
    return (int'(ch) == NUM_CHANNELS - 1) ? '0 : ch + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_ff1 <= 1'b0;
      enable_ff2 <= 1'b0;
    end else begin
      enable_ff1 <= enable;
      enable_ff2 <= enable_ff1;
    end
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = tx_sop_ch[i] && (weight_ch[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0) && enable_ff2;
    end
  end

  slink_rr_pick #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_rr_pick (
    .req   (eligible),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    if (state == ST_LOCK) begin
      curr_ch = owner;
    end else if (pick_found) begin
      curr_ch = pick_idx;
    end else begin
      curr_ch = rr_ptr;
    end
  end

  assign tx_sop        = tx_sop_ch[curr_ch];
  assign tx_data_id    = tx_data_id_ch[int'(curr_ch)*8 +: 8];
  assign tx_word_count = tx_word_count_ch[int'(curr_ch)*16 +: 16];
  assign tx_app_data   = tx_app_data_ch[int'(curr_ch)*TX_APP_DATA_WIDTH +: TX_APP_DATA_WIDTH];
  assign active_ch     = curr_ch;
  assign pkt_active    = (state == ST_LOCK);

  assign curr_wgt      = weight_ch[int'(curr_ch)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign owner_nxt_wgt = weight_ch[int'(owner_nxt)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign hdr_beats     = pkt_beats(tx_data_id, tx_word_count, BYTE_SHIFT);

  always_comb begin
    tx_advance_ch = '0;
    if (state == ST_LOCK || pick_found) begin
      tx_advance_ch[curr_ch] = tx_advance;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    beat_cnt_nxt  = beat_cnt;
    wgt_cnt_nxt   = wgt_cnt;
    rr_ptr_nxt    = rr_ptr;
    done_pend_nxt = 1'b0;
    pkt_done      = 1'b0;

    // Owner stopped requesting right after its packet: move on past it.
    if (done_pend && !eligible[owner]) begin
      rr_ptr_nxt = rr_inc(owner);
    end

    case (state)
      ST_IDLE: begin
        if (pick_found && tx_advance) begin
          owner_nxt = pick_idx;
          if (pick_idx != owner || wgt_cnt == '0) begin
            wgt_cnt_nxt = curr_wgt - 1'b1;
          end else begin
            wgt_cnt_nxt = wgt_cnt - 1'b1;
          end
          if (hdr_beats == beat_t'(1)) begin
            pkt_done = 1'b1;
          end else begin
            state_nxt    = ST_LOCK;
            beat_cnt_nxt = hdr_beats - beat_t'(1);
          end
        end
      end
      ST_LOCK: begin
        if (tx_advance) begin
          beat_cnt_nxt = beat_cnt - beat_t'(1);
          if (beat_cnt == beat_t'(1)) begin
            state_nxt = ST_IDLE;
            pkt_done  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (pkt_done) begin
      done_pend_nxt = 1'b1;
      if (wgt_cnt_nxt == '0 || owner_nxt_wgt == '0) begin
        rr_ptr_nxt = rr_inc(owner_nxt);
      end else begin
        rr_ptr_nxt = owner_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      beat_cnt  <= '0;
      wgt_cnt   <= '0;
      rr_ptr    <= '0;
      done_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      beat_cnt  <= beat_cnt_nxt;
      wgt_cnt   <= wgt_cnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
      done_pend <= done_pend_nxt;
    end
  end

endmodule

// File: tb/tb_slink_generic_tx_router_wrr.sv
// Directed bench for the WRR TX router: grant order, packet locking, weights, enable and reset.
module tb_slink_generic_tx_router_wrr;

  localparam int N  = 8;
  localparam int DW = 64;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N*WW-1:0] weight_ch;
  logic [N-1:0]    tx_sop_ch;
  logic [N*8-1:0]  tx_data_id_ch;
  logic [N*16-1:0] tx_word_count_ch;
  logic [N*DW-1:0] tx_app_data_ch;
  logic [N-1:0]    tx_advance_ch;
  logic            tx_sop;
  logic [7:0]      tx_data_id;
  logic [15:0]     tx_word_count;
  logic [DW-1:0]   tx_app_data;
  logic            tx_advance;
  logic [2:0]      active_ch;
  logic            pkt_active;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  slink_generic_tx_router_wrr #(
    .NUM_CHANNELS      (N),
    .TX_APP_DATA_WIDTH (DW),
    .WEIGHT_WIDTH      (WW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .weight_ch        (weight_ch),
    .tx_sop_ch        (tx_sop_ch),
    .tx_data_id_ch    (tx_data_id_ch),
    .tx_word_count_ch (tx_word_count_ch),
    .tx_app_data_ch   (tx_app_data_ch),
    .tx_advance_ch    (tx_advance_ch),
    .tx_sop           (tx_sop),
    .tx_data_id       (tx_data_id),
    .tx_word_count    (tx_word_count),
    .tx_app_data      (tx_app_data),
    .tx_advance       (tx_advance),
    .active_ch        (active_ch),
    .pkt_active       (pkt_active)
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Cycle status: channel granted, one-hot advance, lock flag.
  task automatic chk_cyc(input string tag, input int ch, input logic [7:0] adv_oh, input logic lock);
    chk({tag, ".active_ch"}, 64'(active_ch), 64'(ch));
    chk({tag, ".adv_ch"}, 64'(tx_advance_ch), 64'(adv_oh));
    chk({tag, ".pkt_active"}, 64'(pkt_active), 64'(lock));
  endtask

  // Inputs change 1 unit after the rising edge; checks run 3 units after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int ch, input logic [7:0] id, input logic [15:0] wc);
    tx_data_id_ch[ch*8 +: 8]     = id;
    tx_word_count_ch[ch*16 +: 16] = wc;
  endtask

  int exp3 [8] = '{1, 1, 1, 3, 1, 1, 1, 3};

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    tx_advance = 1'b0;
    tx_sop_ch  = 8'h01;
    for (int i = 0; i < N; i++) begin
      weight_ch[i*WW +: WW]   = 4'd1;
      tx_app_data_ch[i*DW +: DW] = 64'h0101_0101_0101_0101 * i;
      set_pkt(i, 8'h10, 16'd0);
    end
    set_pkt(0, 8'hA5, 16'd0);
    #3;
    chk_cyc("reset", 0, 8'h00, 1'b0);
    chk("reset.tx_sop", 64'(tx_sop), 64'd1);
    chk("reset.tx_data_id", 64'(tx_data_id), 64'hA5);

    #4 reset  = 1'b1;
    enable = 1'b1;
    set_pkt(0, 8'h10, 16'd0);
    tick; tick; tick;
    chk_cyc("no_adv_no_grant", 0, 8'h00, 1'b0);

    // 1: ch0,1,4 short packets, ch0 keeps requesting.
    tx_sop_ch  = 8'b0001_0011;
    tx_advance = 1'b1;
    #2 chk_cyc("t1.a", 0, 8'h01, 1'b0);
    tick;
    #2 chk_cyc("t1.b", 1, 8'h02, 1'b0);
    chk("t1.b.data", tx_app_data, 64'h0101_0101_0101_0101);
    tick;
    tx_sop_ch[1] = 1'b0;
    #2 chk_cyc("t1.c", 4, 8'h10, 1'b0);
    tick;
    tx_sop_ch[4] = 1'b0;
    #2 chk_cyc("t1.d", 0, 8'h01, 1'b0);
    tick;
    tx_sop_ch = '0;
    #2 chk_cyc("t1.idle_adv_ignored", 1, 8'h00, 1'b0);
    tick;

    // 2: ch2 long packet wc=20 -> 3 advances; ch0 joins mid-packet and drops-out ch2 keeps lock.
    set_pkt(2, 8'h2A, 16'd20);
    tx_sop_ch = 8'b0000_0100;
    #2 chk_cyc("t2.hdr", 2, 8'h04, 1'b0);
    chk("t2.wc", 64'(tx_word_count), 64'd20);
    tick;
    tx_sop_ch  = 8'b0000_0001;
    tx_advance = 1'b0;
    #2 chk_cyc("t2.stall", 2, 8'h00, 1'b1);
    tick;
    tx_advance = 1'b1;
    #2 chk_cyc("t2.beat2", 2, 8'h04, 1'b1);
    tick;
    #2 chk_cyc("t2.beat3", 2, 8'h04, 1'b1);
    tick;
    #2 chk_cyc("t2.next", 0, 8'h01, 1'b0);
    tick;
    tx_sop_ch = '0;

    // 3: ch1 weight 3 vs ch3 weight 1, continuous short packets.
    weight_ch[1*WW +: WW] = 4'd3;
    tx_sop_ch = 8'b0000_1010;
    for (int i = 0; i < 8; i++) begin
      #2 chk_cyc($sformatf("t3.%0d", i), exp3[i], 8'(1 << exp3[i]), 1'b0);
      tick;
    end
    tx_sop_ch = '0;

    // 4: weight-0 channel requesting is never granted; pointer shown.
    weight_ch[5*WW +: WW] = 4'd0;
    tx_sop_ch = 8'b0010_0000;
    #2 chk_cyc("t4.a", 4, 8'h00, 1'b0);
    tick;
    #2 chk_cyc("t4.b", 4, 8'h00, 1'b0);
    tick;
    weight_ch[5*WW +: WW] = 4'd1;
    tx_sop_ch = '0;

    // 5: enable dropped two beats into a 5-beat packet on ch6.
    set_pkt(6, 8'h2A, 16'd40);
    tx_sop_ch = 8'b0100_0000;
    #2 chk_cyc("t5.b1", 6, 8'h40, 1'b0);
    tick;
    #2 chk_cyc("t5.b2", 6, 8'h40, 1'b1);
    enable = 1'b0;
    tick;
    for (int i = 3; i <= 5; i++) begin
      #2 chk_cyc($sformatf("t5.b%0d", i), 6, 8'h40, 1'b1);
      tick;
    end
    tx_sop_ch = 8'b0100_0010;
    #2 chk_cyc("t5.disabled.a", 7, 8'h00, 1'b0);
    tick;
    #2 chk_cyc("t5.disabled.b", 7, 8'h00, 1'b0);
    enable     = 1'b1;
    tx_advance = 1'b0;
    tick; tick; tick;
    tx_advance = 1'b1;
    #2 chk_cyc("t5.resume", 1, 8'h02, 1'b0);
    tick;
    tx_sop_ch = '0;
    tick;

    // 6: reset while locked at beat 3 of 6.
    set_pkt(3, 8'h2A, 16'd48);
    tx_sop_ch = 8'b0000_1000;
    #2 chk_cyc("t6.b1", 3, 8'h08, 1'b0);
    tick;
    #2 chk_cyc("t6.b2", 3, 8'h08, 1'b1);
    tick;
    #2 chk_cyc("t6.b3", 3, 8'h08, 1'b1);
    reset = 1'b0;
    #1 chk_cyc("t6.in_reset", 0, 8'h00, 1'b0);
    tick;
    #2 chk_cyc("t6.held_reset", 0, 8'h00, 1'b0);
    reset      = 1'b1;
    tx_advance = 1'b0;
    tick; tick; tick;
    tx_advance = 1'b1;
    #2 chk_cyc("t6.fresh_hdr", 3, 8'h08, 1'b0);
    tick;
    #2 chk_cyc("t6.fresh_b2", 3, 8'h08, 1'b1);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
